// File: rtl/sigma_delta_adc.sv
// ---------------------------------------------------------------------------
// sigma_delta_adc
//
// First-order sigma-delta front end for a tape EAR input. An external
// comparator compares an RC integrator against midrail. This block
// synchronises the comparator output, drives the inverted bit back into the
// integrator resistor, and decimates the feedback bitstream. Decimation is a
// boxcar count of feedback ones over 2^DECIM_LOG2 clocks.
//
// Parameters
//   DECIM_LOG2   log2 of the decimation window length (6..10)
//   HYST_HI      8-bit sample level at or above which ear_out sets
//   HYST_LO      8-bit sample level at or below which ear_out clears
//                (HYST_LO < HYST_HI)
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   cmp_in        in   comparator output, asynchronous to clk
//   fb_out        out  1-bit feedback to the integrator, direct flop output
//   sample [7:0]  out  decimated unsigned sample, held between updates
//   sample_valid  out  one-clock pulse marking a sample update
//   clip          out  window was all-0 or all-1 (qualified by sample_valid)
//   ear_out       out  hysteresis-sliced level derived from sample
// ---------------------------------------------------------------------------
module sigma_delta_adc #(
    parameter int DECIM_LOG2 = 8,
    parameter int HYST_HI    = 144,
    parameter int HYST_LO    = 112
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmp_in,
    output logic       fb_out,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       clip,
    output logic       ear_out
);

    localparam int             N         = DECIM_LOG2;
    localparam logic [7:0]     LP_HI     = 8'(HYST_HI);
    localparam logic [7:0]     LP_LO     = 8'(HYST_LO);
    localparam logic [N-1:0]   LP_PH_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [7:0]     LP_MID    = 8'h80;

    // synchroniser and feedback
    logic         r_s1;
    logic         r_s2;
    logic         r_fb;

    // decimator
    logic [N-1:0] r_phase;
    logic [N:0]   r_acc;

    // output registers
    logic [7:0]   r_sample;
    logic         r_sample_valid;
    logic         r_clip;
    logic         r_ear;

    logic         w_last;
    logic [N:0]   w_ones;
    logic [N-1:0] w_sat;
    logic [7:0]   w_v;
    logic         w_clip;
    logic         w_ear_next;

    // -----------------------------------------------------------------------
    // Comparator synchroniser. The feedback is the inverted synchronised
    // comparator bit, so cmp_in reaches fb_out on the third rising edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_fb <= 1'b0;
        end else begin
            r_s1 <= cmp_in;
            r_s2 <= r_s1;
            r_fb <= ~r_s2;
        end
    end

    // -----------------------------------------------------------------------
    // Boxcar decimator. The accumulator has collected 2^N-1 feedback bits
    // when the phase counter reaches its last value. Adding the current bit
    // gives a count of 0..2^N. A count of exactly 2^N is the only case that
    // sets the top bit, so that bit doubles as the all-ones detector.
    // -----------------------------------------------------------------------
    assign w_last = &r_phase;
    assign w_ones = r_acc + {{N{1'b0}}, r_fb};
    assign w_sat  = w_ones[N] ? {N{1'b1}} : w_ones[N-1:0];
    assign w_clip = (w_ones == '0) || w_ones[N];

    generate
        if (N >= 8) begin : g_scale_down
            assign w_v = w_sat[N-1 -: 8];
        end else begin : g_scale_up
            assign w_v = {w_sat, {(8-N){1'b0}}};
        end
    endgenerate

    always_comb begin
        w_ear_next = r_ear;
        if (w_v >= LP_HI) begin
            w_ear_next = 1'b1;
        end else if (w_v <= LP_LO) begin
            w_ear_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_acc   <= '0;
        end else begin
            r_phase <= r_phase + LP_PH_ONE;
            if (w_last) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_ones;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stage. There is no backpressure: sample simply holds until the
    // next window closes, and clip and ear_out only move on that same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample       <= LP_MID;
            r_sample_valid <= 1'b0;
            r_clip         <= 1'b0;
            r_ear          <= 1'b0;
        end else begin
            r_sample_valid <= w_last;
            if (w_last) begin
                r_sample <= w_v;
                r_clip   <= w_clip;
                r_ear    <= w_ear_next;
            end
        end
    end

    assign fb_out       = r_fb;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign clip         = r_clip;
    assign ear_out      = r_ear;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// ---------------------------------------------------------------------------
// tb_sigma_delta_adc
//
// Bench for sigma_delta_adc with default parameters (256-clock window).
// A reference model follows cmp_in through the three-edge feedback pipeline
// and counts feedback ones per window. When a window closes, the model
// pushes the expected sample, clip and ear_out values onto a queue. A
// monitor on the falling edge compares the DUT against the model every
// cycle. On each sample_valid it pops the queue and checks that the pulses
// are 256 clocks apart. Directed tasks add explicit checks on the
// scenario values.
// ---------------------------------------------------------------------------
module tb_sigma_delta_adc;

    logic       clk;
    logic       rst_n;
    logic       cmp_in;
    logic       fb_out;
    logic [7:0] sample;
    logic       sample_valid;
    logic       clip;
    logic       ear_out;

    int errors = 0;
    int checks = 0;

    sigma_delta_adc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmp_in       (cmp_in),
        .fb_out       (fb_out),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clip         (clip),
        .ear_out      (ear_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- stimulus generator ----------------
    // mode 0: low, 1: high, 2: square period 8, 3: low for low_n of 8, 4: random
    int mode  = 0;
    int low_n = 4;
    int d_cnt = 0;

    always @(negedge clk) begin
        d_cnt = d_cnt + 1;
        case (mode)
            0:       cmp_in = 1'b0;
            1:       cmp_in = 1'b1;
            2:       cmp_in = (d_cnt % 8) >= 4;
            3:       cmp_in = (d_cnt % 8) >= low_n;
            default: cmp_in = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       e;
    } exp_t;

    exp_t       q[$];
    int         m_phase  = 0;
    int         m_cnt    = 0;
    int         m_ones   = 0;
    logic       m_s1     = 1'b0;
    logic       m_s2     = 1'b0;
    logic       m_fb     = 1'b0;
    logic [7:0] m_sample = 8'h80;
    logic [7:0] m_v      = 8'h00;
    logic       m_clip   = 1'b0;
    logic       m_ear    = 1'b0;
    logic       m_valid  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_cnt    = 0;
            m_s1     = 1'b0;
            m_s2     = 1'b0;
            m_fb     = 1'b0;
            m_sample = 8'h80;
            m_clip   = 1'b0;
            m_ear    = 1'b0;
            m_valid  = 1'b0;
            q.delete();
        end else begin
            m_ones  = m_cnt + (m_fb ? 1 : 0);
            m_valid = 1'b0;
            if (m_phase == 255) begin
                m_v      = (m_ones > 255) ? 8'd255 : 8'(m_ones);
                m_sample = m_v;
                m_clip   = (m_ones == 0) || (m_ones == 256);
                if (m_v >= 8'd144)
                    m_ear = 1'b1;
                else if (m_v <= 8'd112)
                    m_ear = 1'b0;
                m_valid = 1'b1;
                q.push_back('{s: m_v, c: m_clip, e: m_ear});
                m_cnt   = 0;
                m_phase = 0;
            end else begin
                m_cnt   = m_ones;
                m_phase = m_phase + 1;
            end
            m_fb = ~m_s2;
            m_s2 = m_s1;
            m_s1 = cmp_in;
        end
    end

    // ---------------- monitor ----------------
    int   n_since = 0;
    exp_t e_pop;

    always @(negedge clk) begin
        if (!rst_n)
            n_since = 0;
        else
            n_since = n_since + 1;

        checks = checks + 5;
        if (sample_valid !== m_valid) begin
            errors = errors + 1;
            $display("FAIL mon_valid t=%0t: got %b, want %b", $time, sample_valid, m_valid);
        end
        if (fb_out !== m_fb) begin
            errors = errors + 1;
            $display("FAIL mon_fb t=%0t: got %b, want %b", $time, fb_out, m_fb);
        end
        if (sample !== m_sample) begin
            errors = errors + 1;
            $display("FAIL mon_sample t=%0t: got %h, want %h", $time, sample, m_sample);
        end
        if (clip !== m_clip) begin
            errors = errors + 1;
            $display("FAIL mon_clip t=%0t: got %b, want %b", $time, clip, m_clip);
        end
        if (ear_out !== m_ear) begin
            errors = errors + 1;
            $display("FAIL mon_ear t=%0t: got %b, want %b", $time, ear_out, m_ear);
        end

        if (sample_valid === 1'b1) begin
            checks = checks + 2;
            if (n_since != 256) begin
                errors = errors + 1;
                $display("FAIL pulse_spacing t=%0t: got %0d clocks, want 256", $time, n_since);
            end
            n_since = 0;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_empty t=%0t: got pulse with sample %h, want no pulse", $time, sample);
            end else begin
                e_pop = q.pop_front();
                if ({sample, clip, ear_out} !== {e_pop.s, e_pop.c, e_pop.e}) begin
                    errors = errors + 1;
                    $display("FAIL sb_pop t=%0t: got s=%h c=%b e=%b, want s=%h c=%b e=%b",
                             $time, sample, clip, ear_out, e_pop.s, e_pop.c, e_pop.e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic wait_pulse(output int gap);
        gap = 0;
        checks = checks + 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            gap = gap + 1;
            if (sample_valid === 1'b1) return;
        end
        errors = errors + 1;
        $display("FAIL wait_pulse: got no sample_valid in 400 clocks, want one");
    endtask

    task automatic check_reset_values(input string tag);
        checks = checks + 1;
        if ({sample, sample_valid, clip, ear_out, fb_out} !== {8'h80, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors = errors + 1;
            $display("FAIL %s: got s=%h v=%b c=%b e=%b fb=%b, want s=80 v=0 c=0 e=0 fb=0",
                     tag, sample, sample_valid, clip, ear_out, fb_out);
        end
    endtask

    task automatic check_pulse(input string tag, input logic [7:0] s, input logic c, input logic e);
        checks = checks + 1;
        if ({sample, clip, ear_out} !== {s, c, e}) begin
            errors = errors + 1;
            $display("FAIL %s: got s=%0d c=%b e=%b, want s=%0d c=%b e=%b",
                     tag, sample, clip, ear_out, s, c, e);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        mode   = 0;
        cmp_in = 1'b0;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_async");
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        #2 rst_n = 1'b1;
    endtask

    task automatic test_cmp_low();
        int gap;
        wait_pulse(gap);
        checks = checks + 1;
        if (gap != 256) begin
            errors = errors + 1;
            $display("FAIL first_pulse_latency: got %0d, want 256", gap);
        end
        check_pulse("low_win1", 8'hFF, 1'b0, 1'b1);
        wait_pulse(gap);
        check_pulse("low_win2", 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_cmp_high();
        int gap;
        mode = 1;
        wait_pulse(gap);
        wait_pulse(gap);
        check_pulse("high_win2", 8'h00, 1'b1, 1'b0);
        wait_pulse(gap);
        check_pulse("high_win3", 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_square();
        int gap;
        mode = 2;
        wait_pulse(gap);
        wait_pulse(gap);
        check_pulse("square_win2", 8'h80, 1'b0, 1'b0);
        wait_pulse(gap);
        check_pulse("square_win3", 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_duty();
        int gap;
        mode  = 3;
        low_n = 5;
        wait_pulse(gap);
        wait_pulse(gap);
        check_pulse("duty_160", 8'd160, 1'b0, 1'b1);
        low_n = 4;
        wait_pulse(gap);
        wait_pulse(gap);
        check_pulse("duty_128", 8'd128, 1'b0, 1'b1);
        low_n = 3;
        wait_pulse(gap);
        wait_pulse(gap);
        check_pulse("duty_96", 8'd96, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int gap;
        mode = 4;
        wait_pulse(gap);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_phase == 100) break;
        end
        checks = checks + 1;
        if (m_phase != 100) begin
            errors = errors + 1;
            $display("FAIL mid_phase: got model phase %0d, want 100", m_phase);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_reset_async");
        repeat (4) @(negedge clk);
        check_reset_values("mid_reset_held");
        #2 rst_n = 1'b1;
        wait_pulse(gap);
        checks = checks + 1;
        if (gap != 256) begin
            errors = errors + 1;
            $display("FAIL mid_release_latency: got %0d, want 256", gap);
        end
    endtask

    task automatic test_random();
        int gap;
        mode = 4;
        for (int w = 0; w < 10; w++) begin
            wait_pulse(gap);
            checks = checks + 1;
            if (gap != 256) begin
                errors = errors + 1;
                $display("FAIL random_gap w=%0d: got %0d, want 256", w, gap);
            end
        end
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_leftover: got %0d queued, want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_cmp_low();
        test_cmp_high();
        test_square();
        test_duty();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sigma_delta_adc.md
SIGMA_DELTA_ADC -- requirements
Module: sigma_delta_adc

Interface
REQ-001 The block SHALL have parameter DECIM_LOG2, default 8, meaning log2 of the decimation window length (legal range 6..10).
REQ-002 The block SHALL have parameter HYST_HI, default 144, meaning the 8-bit sample threshold at or above which ear_out sets.
REQ-003 The block SHALL have parameter HYST_LO, default 112, meaning the 8-bit sample threshold at or below which ear_out clears; HYST_LO < HYST_HI is required.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmp_in  input  1  external comparator output (RC integrator vs. midrail), asynchronous to clk.
REQ-007 fb_out  output  1  1-bit feedback to the RC integrator resistor; SHALL be a direct flop output.
REQ-008 sample  output  8  decimated, unsigned sample; 0x00 = minimum input, 0xFF = maximum input.
REQ-009 sample_valid  output  1  one-clock pulse marking an update of sample.
REQ-010 clip  output  1  qualified by sample_valid; high when the window was all-0 or all-1.
REQ-011 ear_out  output  1  hysteresis-sliced digital level for the tape EAR path.

Function
REQ-012 cmp_in SHALL pass through a 2-flop synchronizer (s1 <= cmp_in; s2 <= s1).
REQ-013 fb_out SHALL register ~s2 every clock; cmp_in to fb_out latency = 3 rising edges.
REQ-014 A phase counter of DECIM_LOG2 bits SHALL increment every clock and wrap from 2^N-1 to 0 (N = DECIM_LOG2).
REQ-015 Every clock, ones = acc + fb_out (current registered value), with acc N+1 bits wide.
REQ-016 When the phase counter != 2^N-1, acc SHALL load ones.
REQ-017 When the phase counter == 2^N-1, acc SHALL load 0 and a sample SHALL be produced from ones on the same edge.
REQ-018 Sample production: sat = min(ones, 2^N-1).
REQ-019 If N >= 8, sample SHALL load sat >> (N-8); if N < 8, sample SHALL load sat << (8-N).
REQ-020 On sample production, sample_valid SHALL be 1 for exactly the following clock; at all other times it SHALL be 0.
REQ-021 On sample production, clip SHALL load (ones == 0) or (ones == 2^N); at all other times clip SHALL hold.
REQ-022 ear_out SHALL update only on sample production, from the new 8-bit value v: set to 1 if v >= HYST_HI; set to 0 if v <= HYST_LO; otherwise hold.
REQ-023 sample_valid pulses SHALL be spaced exactly 2^N clocks apart.
REQ-024 No backpressure: a consumer that misses a pulse SHALL lose that sample; sample SHALL hold its value between pulses.

Reset
REQ-025 While rst_n = 0, outputs SHALL immediately and independently of clk take: s1 = s2 = 0, fb_out = 0, phase counter = 0, acc = 0, sample = 0x80, sample_valid = 0, clip = 0, ear_out = 0.
REQ-026 Assertion mid-window SHALL discard the partial window; no sample_valid SHALL be issued for it.
REQ-027 After rst_n rises, the first sample_valid SHALL be asserted on the clock following the 2^N-th rising edge.

Verification
REQ-028 Scenario (N=8): cmp_in held 0 from reset -> first window sample = 0xFF, clip = 0 (fb_out 0 for one cycle); second window sample = 0xFF, clip = 1; ear_out = 1.
REQ-029 Scenario: cmp_in held 1 -> from the second window, sample = 0x00, clip = 1, ear_out = 0.
REQ-030 Scenario: cmp_in square wave of period 8 clocks, 50% duty -> steady-state sample = 0x80, clip = 0, ear_out unchanged.
REQ-031 Scenario: cmp_in duty set so the expected sample is 160, then 128, then 96 -> ear_out goes 1, stays 1, then goes 0.
REQ-032 Scenario: rst_n pulsed low at phase count 100 -> all outputs take reset values asynchronously, with no pulse for the aborted window; the next sample_valid occurs 256 clocks after release.
REQ-033 Scenario: 10 consecutive windows with random cmp_in -> pulses exactly 256 clocks apart, each one clock wide, and sample equals a reference model count of fb_out ones.
